// File: rtl/nqueens_pkg.sv
// Shared constants for the N-queens CFU: function IDs, FSM states and response codes.
package nqueens_pkg;

  localparam int N_MAX_DEFAULT = 16;

  localparam logic [9:0] FN_INIT       = 10'd0;
  localparam logic [9:0] FN_RUN        = 10'd1;
  localparam logic [9:0] FN_GET_RET    = 10'd2;
  localparam logic [9:0] FN_GET_CYCLES = 10'd3;
  localparam logic [9:0] FN_STEP       = 10'd4;

  localparam logic [31:0] RSP_ERR    = 32'hFFFF_FFFF;
  localparam logic [31:0] RSP_BUDGET = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOLVE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/nqueens_stack.sv
// Backtracking stack for the N-queens solver: candidate, column, and both diagonal masks per level.
module nqueens_stack
  import nqueens_pkg::*;
#(
  parameter int DEPTH = N_MAX_DEFAULT + 2,
  parameter int WIDTH = N_MAX_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_cdt,
  input  logic [WIDTH-1:0] wr_col,
  input  logic [WIDTH-1:0] wr_pos,
  input  logic [WIDTH-1:0] wr_neg,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_cdt,
  output logic [WIDTH-1:0] rd_col,
  output logic [WIDTH-1:0] rd_pos,
  output logic [WIDTH-1:0] rd_neg
);

  logic [WIDTH-1:0] cdt [DEPTH];
  logic [WIDTH-1:0] col [DEPTH];
  logic [WIDTH-1:0] pos [DEPTH];
  logic [WIDTH-1:0] neg [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        cdt[i] <= '0;
        col[i] <= '0;
        pos[i] <= '0;
        neg[i] <= '0;
      end
    end else if (we) begin
      cdt[wr_addr] <= wr_cdt;
      col[wr_addr] <= wr_col;
      pos[wr_addr] <= wr_pos;
      neg[wr_addr] <= wr_neg;
    end
  end

  // Combinational read so a full tree step fits in one cycle.
  assign rd_cdt = cdt[rd_addr];
  assign rd_col = col[rd_addr];
  assign rd_pos = pos[rd_addr];
  assign rd_neg = neg[rd_addr];

endmodule

// File: rtl/nqueens_solver_cfu.sv
// Autonomous N-queens backtracking CFU; one tree step per cycle while solving.
// Optional NQ_CYCLE_COUNT_EN adds a solve-cycle counter and a per-RUN cycle budget.
module nqueens_solver_cfu
  import nqueens_pkg::*;
#(
  parameter int N_MAX     = N_MAX_DEFAULT,
  parameter int MW        = N_MAX,
  parameter int TIMEOUT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  input  logic [31:0] cmd_payload_inputs_2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int HW = $clog2(N_MAX + 2);

  state_t          state;
  logic [31:0]     ret;
  logic [HW-1:0]   h;
  logic [HW-1:0]   n;
  logic [MW-1:0]   r;
  logic            inited;

  logic [MW-1:0]   st_cdt, st_col, st_pos, st_neg;
  logic [MW-1:0]   lsb, col_nx, pos_nx, neg_nx, r_push, init_col;
  logic            done, leaf, can_step, init_ok, budget_hit, do_step, stack_we;
  logic [HW-1:0]   wr_addr;
  logic [31:0]     cycles_rsp;
  logic            unused_bits;

  assign lsb    = r & (~r + MW'(1));
  assign col_nx = st_col & ~lsb;
  assign pos_nx = (st_pos | lsb) << 1;
  assign neg_nx = (st_neg | lsb) >> 1;
  assign r_push = col_nx & ~(pos_nx | neg_nx);

  assign done     = (r == '0) && (h == HW'(1));
  assign leaf     = (h == n + HW'(1));
  assign can_step = inited && !done;
  assign init_ok  = (cmd_payload_inputs_0 != 32'd0) && (cmd_payload_inputs_0 <= 32'(N_MAX));
  assign init_col = {MW{1'b1}} >> (32'(MW) - cmd_payload_inputs_0);

  assign do_step = (state == ST_SOLVE && !done && !budget_hit) ||
                   (state == ST_IDLE && cmd_valid &&
                    cmd_payload_function_id == FN_STEP && can_step);

  // INIT seeds level 1; every push writes the next level.
  assign stack_we = (do_step && r != '0) ||
                    (state == ST_IDLE && cmd_valid &&
                     cmd_payload_function_id == FN_INIT && init_ok);
  assign wr_addr  = (state == ST_IDLE && cmd_payload_function_id == FN_INIT) ?
                    HW'(1) : h + HW'(1);

  assign unused_bits = ^cmd_payload_inputs_1;

`ifdef NQ_CYCLE_COUNT_EN
  logic [TIMEOUT_W-1:0] cycles, run_cycles, budget;
  assign budget_hit = (budget != '0) && (run_cycles == budget);
  assign cycles_rsp = 32'(cycles);
`else
  assign budget_hit = 1'b0;
  assign cycles_rsp = cmd_payload_inputs_2;
`endif

  nqueens_stack #(
    .DEPTH (N_MAX + 2),
    .WIDTH (MW),
    .AW    (HW)
  ) u_stack (
    .clk     (clk),
    .reset   (reset),
    .we      (stack_we),
    .wr_addr (wr_addr),
    .wr_cdt  (state == ST_IDLE && cmd_payload_function_id == FN_INIT ? '0 : r & ~lsb),
    .wr_col  (state == ST_IDLE && cmd_payload_function_id == FN_INIT ? init_col : col_nx),
    .wr_pos  (state == ST_IDLE && cmd_payload_function_id == FN_INIT ? '0 : pos_nx),
    .wr_neg  (state == ST_IDLE && cmd_payload_function_id == FN_INIT ? '0 : neg_nx),
    .rd_addr (h),
    .rd_cdt  (st_cdt),
    .rd_col  (st_col),
    .rd_pos  (st_pos),
    .rd_neg  (st_neg)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      cmd_ready             <= 1'b1;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      ret                   <= '0;
      h                     <= '0;
      r                     <= '0;
      n                     <= '0;
      inited                <= 1'b0;
`ifdef NQ_CYCLE_COUNT_EN
      cycles                <= '0;
      run_cycles            <= '0;
      budget                <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            case (cmd_payload_function_id)
              FN_INIT: begin
                if (init_ok) begin
                  ret                   <= '0;
                  h                     <= HW'(1);
                  r                     <= cmd_payload_inputs_1[MW-1:0] & init_col;
                  n                     <= HW'(cmd_payload_inputs_0);
                  inited                <= 1'b1;
                  rsp_payload_outputs_0 <= '0;
`ifdef NQ_CYCLE_COUNT_EN
                  cycles                <= '0;
`endif
                end else begin
                  rsp_payload_outputs_0 <= RSP_ERR;
                end
              end
              FN_RUN: begin
                if (can_step) begin
                  state     <= ST_SOLVE;
                  rsp_valid <= 1'b0;
`ifdef NQ_CYCLE_COUNT_EN
                  run_cycles <= '0;
                  budget     <= TIMEOUT_W'(cmd_payload_inputs_2);
`endif
                end else begin
                  rsp_payload_outputs_0 <= ret;
                end
              end
              FN_GET_RET:    rsp_payload_outputs_0 <= ret;
              FN_GET_CYCLES: rsp_payload_outputs_0 <= cycles_rsp;
              FN_STEP:       rsp_payload_outputs_0 <= {31'd0, can_step};
              default:       rsp_payload_outputs_0 <= RSP_ERR;
            endcase
          end
        end
        ST_SOLVE: begin
          if (done || budget_hit) begin
            state                 <= ST_RESP;
            rsp_valid             <= 1'b1;
            rsp_payload_outputs_0 <= done ? ret : RSP_BUDGET;
          end else begin
`ifdef NQ_CYCLE_COUNT_EN
            if (cycles != '1) cycles <= cycles + 1'b1;
            run_cycles <= run_cycles + 1'b1;
`endif
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (do_step) begin
        if (r != '0) begin
          r <= r_push;
          h <= h + HW'(1);
        end else begin
          if (leaf) ret <= ret + 32'd1;
          r <= st_cdt;
          h <= h - HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nqueens_solver_cfu.sv
// Directed, table-driven bench for nqueens_solver_cfu; NQ_CYCLE_COUNT_EN enables the budget sequence.
module tb_nqueens_solver_cfu;
  import nqueens_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic [31:0] cmd_payload_inputs_2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nqueens_solver_cfu dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .cmd_payload_inputs_2    (cmd_payload_inputs_2),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0)
  );

  typedef struct {
    string       name;
    logic [9:0]  fid;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [9:0] f,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] a2, input logic [31:0] ex);
    vec_t v;
    v.name = nm; v.fid = f; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.exp = ex;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] ex);
    checks++;
    if (got !== ex) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, ex);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  // Called at a negedge; returns at a negedge after the command was accepted.
  task automatic send(input logic [9:0] f, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [31:0] a2);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_wait: got 0 expected 1");
    end
    cmd_valid = 1'b1;
    cmd_payload_function_id = f;
    cmd_payload_inputs_0 = a0;
    cmd_payload_inputs_1 = a1;
    cmd_payload_inputs_2 = a2;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic recv(output logic [31:0] val, output bit ok);
    int k = 0;
    while (!rsp_valid && k < 20000) begin
      @(negedge clk);
      k++;
    end
    ok  = rsp_valid;
    val = rsp_payload_outputs_0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string nm, input logic [9:0] f, input logic [31:0] a0,
                      input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] ex);
    logic [31:0] v;
    bit ok;
    send(f, a0, a1, a2);
    recv(v, ok);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: no response, expected %h", nm, ex);
    end else begin
      check(nm, v, ex);
    end
  endtask

  initial begin
    logic [31:0] v;
    bit ok;
    int k;

    reset = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    cmd_payload_inputs_2 = '0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b1;

    add("get_ret_after_reset", FN_GET_RET,  0,      0,     0, 32'd0);
    add("init_n4",             FN_INIT,     4,      32'hF, 0, 32'd0);
    add("run_n4",              FN_RUN,      0,      0,     0, 32'd2);
    add("get_ret_n4",          FN_GET_RET,  0,      0,     0, 32'd2);
    add("run_n4_again",        FN_RUN,      0,      0,     0, 32'd2);
    add("init_n8_all",         FN_INIT,     8,      32'hFF,0, 32'd0);
    add("run_n8_all",          FN_RUN,      0,      0,     0, 32'd92);
    add("init_n8_col0",        FN_INIT,     8,      32'h1, 0, 32'd0);
    add("run_n8_col0",         FN_RUN,      0,      0,     0, 32'd4);
    add("init_n1",             FN_INIT,     1,      32'h1, 0, 32'd0);
    add("run_n1",              FN_RUN,      0,      0,     0, 32'd1);
    add("init_n0",             FN_INIT,     0,      32'hF, 0, RSP_ERR);
    add("init_n17",            FN_INIT,     17,     32'hF, 0, RSP_ERR);
    add("bad_fid9",            10'd9,       0,      0,     0, RSP_ERR);
    add("get_ret_after_errs",  FN_GET_RET,  0,      0,     0, 32'd1);
`ifndef NQ_CYCLE_COUNT_EN
    add("get_cycles_echo",     FN_GET_CYCLES, 0,    0,     32'h1234_5678, 32'h1234_5678);
`endif

    foreach (vecs[i]) xact(vecs[i].name, vecs[i].fid, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].exp);

    // Single-step the n=4 search to completion.
    xact("init_n4_step", FN_INIT, 4, 32'hF, 0, 32'd0);
    send(FN_STEP, 0, 0, 0);
    recv(v, ok);
    check("step_first", ok ? v : 32'hDEAD_BEEF, 32'd1);
    k = 0;
    while (ok && v == 32'd1 && k < 300) begin
      send(FN_STEP, 0, 0, 0);
      recv(v, ok);
      k++;
    end
    check("step_final", ok ? v : 32'hDEAD_BEEF, 32'd0);
    xact("get_ret_after_steps", FN_GET_RET, 0, 0, 0, 32'd2);
    xact("step_when_done", FN_STEP, 0, 0, 0, 32'd0);

    // Hold off the response: data stays stable and no new command is accepted.
    send(FN_GET_RET, 0, 0, 0);
    k = 0;
    while (!rsp_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      check("hold_rsp_data", rsp_payload_outputs_0, 32'd2);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    reset = 1'b0;
    @(negedge clk);
    check("resp_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("resp_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    xact("get_ret_after_resp_reset", FN_GET_RET, 0, 0, 0, 32'd0);

    // Abort a long n=8 run with reset.
    xact("init_n8_abort", FN_INIT, 8, 32'hFF, 0, 32'd0);
    send(FN_RUN, 0, 0, 0);
    repeat (1500) @(negedge clk);
    check("mid_run_busy", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("solve_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("solve_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    reset = 1'b1;
    xact("get_ret_after_solve_reset", FN_GET_RET, 0, 0, 0, 32'd0);
    xact("run_uninit", FN_RUN, 0, 0, 0, 32'd0);

`ifdef NQ_CYCLE_COUNT_EN
    xact("init_n8_budget", FN_INIT, 8, 32'hFF, 0, 32'd0);
    send(FN_RUN, 0, 0, 32'd100);
    recv(v, ok);
    check("budget_first", ok ? v : 32'hDEAD_BEEF, RSP_BUDGET);
    k = 0;
    while (ok && v == RSP_BUDGET && k < 200) begin
      send(FN_RUN, 0, 0, 32'd100);
      recv(v, ok);
      k++;
    end
    check("budget_final", ok ? v : 32'hDEAD_BEEF, 32'd92);
    xact("get_cycles_reset_by_init", FN_INIT, 4, 32'hF, 0, 32'd0);
    xact("get_cycles_zero", FN_GET_CYCLES, 0, 0, 32'h55, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
